// File: rtl/color_descrambler_stream_pkg.sv
// Shared types and helpers for the RGB channel scrambler/descrambler family.
// Pixels are {R,G,B} with R in the MSBs; channel index 0=R, 1=G, 2=B.
package color_pkg;

   localparam int CODE_W    = 6;
   localparam int MAX_PIX_W = 48;
   localparam int MAX_CH_W  = MAX_PIX_W / 3;

   typedef enum logic [1:0] {
      SEL_R    = 2'd0,
      SEL_G    = 2'd1,
      SEL_B    = 2'd2,
      SEL_ZERO = 2'd3
   } sel_e;

   localparam logic [CODE_W-1:0] IDENTITY_CODE = {SEL_R, SEL_G, SEL_B};

   // Channel k counted from the MSB end; the caller zero-extends the pixel to MAX_PIX_W.
   function automatic logic [MAX_CH_W-1:0] get_channel(
      input logic [MAX_PIX_W-1:0] pix,
      input int unsigned          ch_w,
      input logic [1:0]           k
   );
      return MAX_CH_W'((pix >> (ch_w * (32'd2 - 32'(k)))) & ~({MAX_PIX_W{1'b1}} << ch_w));
   endfunction

endpackage

// File: rtl/color_descrambler_stream_decode.sv
// Inverse of a scramble code: for each original channel, which scrambled
// channel carries it (lowest output channel wins on duplicates), plus lost flags.
module color_inverse_decode
   import color_pkg::*;
(
   input  logic [CODE_W-1:0] i_code,
   output logic [1:0]        o_sel_r,
   output logic [1:0]        o_sel_g,
   output logic [1:0]        o_sel_b,
   output logic [2:0]        o_lost
);

   logic [1:0] w_sel [3];
   logic [2:0] w_found;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         w_sel[k]   = SEL_ZERO;
         w_found[k] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 3; c++) begin
            if (!w_found[k] && (i_code[CODE_W-1-2*c -: 2] == 2'(k))) begin
               w_sel[k]   = 2'(c);
               w_found[k] = 1'b1;
            end
         end
      end
   end

   assign o_sel_r = w_sel[0];
   assign o_sel_g = w_sel[1];
   assign o_sel_b = w_sel[2];
   assign o_lost  = {~w_found[0], ~w_found[1], ~w_found[2]};

endmodule

// File: rtl/color_descrambler_stream.sv
// Two-stage streaming RGB descrambler: S1 captures the pixel with its inverse
// selects, S2 applies them. The scramble code is latched on each accepted sof.
module color_descrambler_stream
   import color_pkg::*;
#(
   parameter int PIX_W = 24,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PIX_W-1:0]  s_pix,
   input  logic              s_valid,
   input  logic              s_sof,
   input  logic              s_eol,
   output logic              s_ready,
   input  logic [CODE_W-1:0] cfg_code,
   output logic [PIX_W-1:0]  m_pix,
   output logic              m_valid,
   output logic              m_sof,
   output logic              m_eol,
   input  logic              m_ready,
   output logic [2:0]        lost_mask,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam int CH_W = PIX_W / 3;

   if (((PIX_W % 3) != 0) || (PIX_W > MAX_PIX_W)) begin : g_param_check
      $error("color_descrambler_stream: PIX_W must be a multiple of 3 and at most %0d", MAX_PIX_W);
   end

   logic [CODE_W-1:0] r_code;
   logic [2:0]        r_lost;
   logic [CNT_W-1:0]  r_frame_cnt;

   logic              r_vld_p1;
   logic [PIX_W-1:0]  r_pix_p1;
   logic              r_sof_p1;
   logic              r_eol_p1;
   logic [1:0]        r_sel_p1 [3];

   logic              r_vld_p2;
   logic [PIX_W-1:0]  r_pix_p2;
   logic              r_sof_p2;
   logic              r_eol_p2;

   logic              w_s2_free;
   logic              w_acc;
   logic              w_acc_sof;
   logic [CODE_W-1:0] w_code;
   logic [1:0]        w_sel [3];
   logic [2:0]        w_lost;
   logic [PIX_W-1:0]  w_pix_mux;

   assign w_s2_free = !r_vld_p2 || m_ready;
   assign s_ready   = !r_vld_p1 || w_s2_free;
   assign w_acc     = s_valid && s_ready;
   assign w_acc_sof = w_acc && s_sof;
   // The sof beat itself already uses the incoming code.
   assign w_code    = w_acc_sof ? cfg_code : r_code;

   color_inverse_decode u_decode (
      .i_code  (w_code),
      .o_sel_r (w_sel[0]),
      .o_sel_g (w_sel[1]),
      .o_sel_b (w_sel[2]),
      .o_lost  (w_lost)
   );

   // ---- S1: capture pixel and its inverse selects ----
   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_pix_p1 <= s_pix;
         r_sof_p1 <= s_sof;
         r_eol_p1 <= s_eol;
         for (int k = 0; k < 3; k++) begin
            r_sel_p1[k] <= w_sel[k];
         end
      end
   end

   always_comb begin
      w_pix_mux = '0;
      for (int k = 0; k < 3; k++) begin
         if (r_sel_p1[k] != SEL_ZERO) begin
            w_pix_mux[PIX_W-1-k*CH_W -: CH_W] =
               CH_W'(get_channel(MAX_PIX_W'(r_pix_p1), CH_W, r_sel_p1[k]));
         end
      end
   end

   // ---- S2: descrambled output register, plus frame-level control ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_code      <= IDENTITY_CODE;
         r_lost      <= '0;
         r_frame_cnt <= '0;
         r_vld_p1    <= 1'b0;
         r_vld_p2    <= 1'b0;
         r_pix_p2    <= '0;
         r_sof_p2    <= 1'b0;
         r_eol_p2    <= 1'b0;
      end else begin
         if (w_acc_sof) begin
            r_code      <= cfg_code;
            r_lost      <= w_lost;
            r_frame_cnt <= r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (s_ready) begin
            r_vld_p1 <= s_valid;
         end
         if (w_s2_free) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
               r_pix_p2 <= w_pix_mux;
               r_sof_p2 <= r_sof_p1;
               r_eol_p2 <= r_eol_p1;
            end
         end
      end
   end

   assign m_pix     = r_pix_p2;
   assign m_valid   = r_vld_p2;
   assign m_sof     = r_sof_p2;
   assign m_eol     = r_eol_p2;
   assign lost_mask = r_lost;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_color_descrambler_stream.sv
// Directed plus randomized bench for color_descrambler_stream with a
// queue-based reference model of the descrambling rules.
module tb_color_descrambler_stream;

   logic        clk;
   logic        rst_n;
   logic [23:0] s_pix;
   logic        s_valid;
   logic        s_sof;
   logic        s_eol;
   logic        s_ready;
   logic [5:0]  cfg_code;
   logic [23:0] m_pix;
   logic        m_valid;
   logic        m_sof;
   logic        m_eol;
   logic        m_ready;
   logic [2:0]  lost_mask;
   logic [15:0] frame_cnt;

   color_descrambler_stream #(.PIX_W(24), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_pix     (s_pix),
      .s_valid   (s_valid),
      .s_sof     (s_sof),
      .s_eol     (s_eol),
      .s_ready   (s_ready),
      .cfg_code  (cfg_code),
      .m_pix     (m_pix),
      .m_valid   (m_valid),
      .m_sof     (m_sof),
      .m_eol     (m_eol),
      .m_ready   (m_ready),
      .lost_mask (lost_mask),
      .frame_cnt (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] pix;
      logic        sof;
      logic        eol;
   } beat_t;

   beat_t       q[$];
   logic [5:0]  mdl_code;
   logic [2:0]  mdl_lost;
   logic [15:0] mdl_cnt;
   int          n_cmp;
   int          n_err;
   logic        hold_v;
   logic [23:0] hold_pix;
   logic        hold_sof;
   logic        hold_eol;

   // Scrambled channel c carries original channel sel[c]; walking c from B up to R
   // lets the lowest c overwrite, so duplicates resolve to the lowest output channel.
   function automatic logic [26:0] descr(input logic [5:0] code, input logic [23:0] pix);
      logic [7:0] orig [3];
      logic [2:0] wr;
      logic [1:0] s;
      for (int k = 0; k < 3; k++) orig[k] = 8'h00;
      wr = 3'b000;
      for (int c = 2; c >= 0; c--) begin
         s = code[5-2*c -: 2];
         if (s != 2'd3) begin
            orig[s] = pix[23-8*c -: 8];
            wr[s]   = 1'b1;
         end
      end
      return {~wr[0], ~wr[1], ~wr[2], orig[0], orig[1], orig[2]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [23:0] p, input logic sof, input logic eol,
                      input logic [5:0] code, input logic rdy);
      s_valid  = v;
      s_pix    = p;
      s_sof    = sof;
      s_eol    = eol;
      cfg_code = code;
      m_ready  = rdy;
   endtask

   // One clock: check outputs against the model, update the model, cross the edge.
   task automatic cycle(output bit acc_in);
      bit          acc_out;
      logic [26:0] r;
      #1;
      chk("s_ready", s_ready, (q.size() == 2 && !m_ready) ? 32'd0 : 32'd1);
      if (hold_v) begin
         chk("stall_vld", m_valid, 1);
         chk("stall_pix", m_pix, hold_pix);
         chk("stall_sof", m_sof, hold_sof);
         chk("stall_eol", m_eol, hold_eol);
      end
      if (m_valid) begin
         if (q.size() == 0) chk("spurious_vld", m_valid, 0);
         else begin
            chk("m_pix", m_pix, q[0].pix);
            chk("m_sof", m_sof, q[0].sof);
            chk("m_eol", m_eol, q[0].eol);
         end
      end
      acc_in   = s_valid && s_ready;
      acc_out  = m_valid && m_ready;
      hold_v   = m_valid && !m_ready;
      hold_pix = m_pix;
      hold_sof = m_sof;
      hold_eol = m_eol;
      if (acc_out && q.size() > 0) void'(q.pop_front());
      if (acc_in) begin
         if (s_sof) begin
            mdl_code = cfg_code;
            r        = descr(cfg_code, 24'h0);
            mdl_lost = r[26:24];
            mdl_cnt  = mdl_cnt + 16'd1;
         end
         r = descr(mdl_code, s_pix);
         q.push_back('{pix: r[23:0], sof: s_sof, eol: s_eol});
      end
      @(posedge clk);
      @(negedge clk);
      chk("lost_mask", lost_mask, mdl_lost);
      chk("frame_cnt", frame_cnt, mdl_cnt);
   endtask

   // Single beat into an empty pipeline; returns m_pix after the two-cycle latency.
   task automatic send_one(input logic [23:0] p, input logic sof, input logic eol,
                           input logic [5:0] code, output logic [23:0] got);
      bit a;
      drv(1'b1, p, sof, eol, code, 1'b1);
      cycle(a);
      chk("send_acc", a, 1);
      drv(1'b0, 24'h0, 1'b0, 1'b0, code, 1'b1);
      chk("lat_early_vld", m_valid, 0);
      cycle(a);
      chk("lat_vld", m_valid, 1);
      got = m_pix;
   endtask

   task automatic drain();
      bit a;
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         drv(1'b0, 24'h0, 1'b0, 1'b0, 6'h00, 1'b1);
         cycle(a);
         n++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      bit          acc;
      int          sent;
      int          ready_low;
      logic [23:0] got;

      n_cmp     = 0;
      n_err     = 0;
      hold_v    = 1'b0;
      hold_pix  = '0;
      hold_sof  = 1'b0;
      hold_eol  = 1'b0;
      mdl_code  = 6'b00_01_10;
      mdl_lost  = 3'b000;
      mdl_cnt   = 16'd0;
      rst_n     = 1'b0;
      drv(1'b0, 24'h0, 1'b0, 1'b0, 6'h00, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_pix", m_pix, 0);
      chk("rst_m_sof", m_sof, 0);
      chk("rst_m_eol", m_eol, 0);
      chk("rst_lost", lost_mask, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_s_ready", s_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Identity before any sof, even with a non-identity cfg_code present.
      send_one(24'h112233, 1'b0, 1'b0, 6'h3F, got);
      chk("identity_pix", got, 24'h112233);
      chk("identity_cnt", frame_cnt, 0);
      drain();

      // Rotation: scrambled {G,B,R}.
      send_one(24'hAABBCC, 1'b1, 1'b0, 6'b01_10_00, got);
      chk("rotate_pix", got, 24'hCCAABB);
      chk("rotate_cnt", frame_cnt, 1);
      chk("rotate_lost", lost_mask, 3'b000);
      drain();

      // Lost R and B channels.
      send_one(24'h005A5A, 1'b1, 1'b1, 6'b11_01_01, got);
      chk("lost_pix", got, 24'h005A00);
      chk("lost_mask_101", lost_mask, 3'b101);
      chk("lost_eol", m_eol, 1);
      drain();

      // Backpressure: 8 beats, downstream stalled for 5 cycles.
      sent      = 0;
      ready_low = 0;
      for (int c = 0; c < 40 && sent < 8; c++) begin
         drv(1'b1, 24'h102030 + 24'(sent * 24'h010101), sent == 0, sent == 3 || sent == 7,
             6'b10_00_01, !(c >= 3 && c < 8));
         if (!s_ready) ready_low++;
         cycle(acc);
         if (acc) sent++;
      end
      chk("bp_sent", sent, 8);
      chk("bp_ready_dropped", ready_low > 0, 1);
      drain();

      // Code changes on a non-sof beat are ignored until the next sof.
      send_one(24'h123456, 1'b1, 1'b0, 6'b10_00_01, got);
      chk("mf_first", got, 24'h345612);
      drain();
      send_one(24'h123456, 1'b0, 1'b0, 6'b00_01_10, got);
      chk("mf_ignored", got, 24'h345612);
      drain();
      send_one(24'h123456, 1'b1, 1'b0, 6'b00_01_10, got);
      chk("mf_applied", got, 24'h123456);
      drain();

      // Randomized traffic with random stalls, sof, eol and cfg_code.
      for (int i = 0; i < 500; i++) begin
         drv($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 15) == 0,
             $urandom_range(0, 7) == 0, 6'($urandom), $urandom_range(0, 3) != 0);
         cycle(acc);
      end
      drain();

      // Reset with both stages full.
      drv(1'b1, 24'hC0FFEE, 1'b1, 1'b0, 6'b01_10_00, 1'b0);
      cycle(acc);
      drv(1'b1, 24'hBADA55, 1'b0, 1'b1, 6'b01_10_00, 1'b0);
      cycle(acc);
      chk("rst_mid_full", q.size(), 2);
      drv(1'b0, 24'h0, 1'b0, 1'b0, 6'b01_10_00, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_m_valid", m_valid, 0);
      chk("rst_mid_m_pix", m_pix, 0);
      chk("rst_mid_cnt", frame_cnt, 0);
      chk("rst_mid_lost", lost_mask, 0);
      q.delete();
      hold_v   = 1'b0;
      mdl_code = 6'b00_01_10;
      mdl_lost = 3'b000;
      mdl_cnt  = 16'd0;
      @(negedge clk);
      rst_n = 1'b1;
      send_one(24'hABCDEF, 1'b0, 1'b0, 6'b01_10_00, got);
      chk("rst_mid_identity", got, 24'hABCDEF);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
